vending_owner: RTL and testbench

Owner-side maintenance port of the vending machine, the writer counterpart to the customer purchase path. It authenticates the owner with a PIN and then executes one-shot commands: restock an item, set an item price, withdraw collected money. Its outputs feed the shared stock/price/saved-money registers that the customer path reads. All behaviour is sequential and registered, with lockout after repeated bad PINs and an idle session timeout.

---
 rtl/vm_pkg.sv | 28 ++
 rtl/vm_field.sv | 33 +++
 rtl/vending_owner.sv | 197 +++++++++++++++++++
 tb/tb_vending_owner.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// vm_pkg: shared definitions for the vending machine owner/customer paths.
//   - mode and command codes
//   - owner session state encoding
//   - item table geometry (5 items, 4-bit fields)
package vm_pkg;

    localparam int NUM_ITEMS = 5;
    localparam int FIELD_W   = 4;
    localparam int VEC_W     = NUM_ITEMS * FIELD_W;
    localparam int MAX_QTY   = 15;

    localparam logic [1:0] MODE_CUSTOMER = 2'b00;
    localparam logic [1:0] MODE_OWNER    = 2'b01;

    typedef enum logic [1:0] {
        CMD_RESTOCK   = 2'b00,
        CMD_SET_PRICE = 2'b01,
        CMD_WITHDRAW  = 2'b10,
        CMD_LOGOUT    = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'b00,
        ST_UNLOCKED = 2'b01,
        ST_LOCKOUT  = 2'b10
    } state_e;

endpackage

// File: rtl/vm_field.sv
// vm_field: combinational extract/insert of one 4-bit field in the packed
// item vector, addressed by a 1-based item index.
//   vec      in  packed item fields, item k at [4k-1:4k-4]
//   idx      in  1-based item index
//   new_val  in  value to insert at idx
//   field    out current field at idx (0 when idx is out of range)
//   vec_out  out vec with field idx replaced by new_val (vec when out of range)
//   valid    out idx is within 1..NUM_ITEMS
module vm_field
    import vm_pkg::*;
(
    input  logic [VEC_W-1:0]   vec,
    input  logic [2:0]         idx,
    input  logic [FIELD_W-1:0] new_val,
    output logic [FIELD_W-1:0] field,
    output logic [VEC_W-1:0]   vec_out,
    output logic               valid
);

    always_comb begin
        field   = '0;
        vec_out = vec;
        valid   = 1'b0;
        for (int k = 1; k <= NUM_ITEMS; k++) begin
            if (idx == 3'(k)) begin
                field                         = vec[k*FIELD_W-1 -: FIELD_W];
                vec_out[k*FIELD_W-1 -: FIELD_W] = new_val;
                valid                         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vending_owner.sv
// vending_owner: owner maintenance port. PIN login with lockout after
// repeated failures, idle auto-logout, and one-shot restock / set price /
// withdraw commands that produce next values for the shared registers.
//   clk, rst                       clock, synchronous active-high reset
//   mode, req, cmd, index_type     machine mode, command strobe and decode
//   in_value                       PIN when locked, operand when unlocked
//   all_number/all_price/saved_money  current shared register values
//   update_*                       next shared register values
//   withdrawn                      amount released by the last withdraw
//   done, error                    one-cycle completion pulse and reject flag
//   unlocked, locked_out           session / lockout status
//
// state       | meaning
// ST_LOCKED   | waiting for PIN
// ST_UNLOCKED | session open, commands accepted, idle timer running
// ST_LOCKOUT  | too many bad PINs, requests ignored until timer expires
module vending_owner
    import vm_pkg::*;
#(
    parameter logic [3:0] PIN         = 4'd9,
    parameter int          MAX_TRIES   = 3,
    parameter int          LOCK_CYCLES = 16,
    parameter int          TIMEOUT     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             req,
    input  logic [1:0]       cmd,
    input  logic [2:0]       index_type,
    input  logic [3:0]       in_value,
    input  logic [VEC_W-1:0] all_number,
    input  logic [VEC_W-1:0] all_price,
    input  logic [3:0]       saved_money,
    output logic [VEC_W-1:0] update_all_number,
    output logic [VEC_W-1:0] update_all_price,
    output logic [3:0]       update_saved_money,
    output logic [3:0]       withdrawn,
    output logic             done,
    output logic             error,
    output logic             unlocked,
    output logic             locked_out
);

    localparam int TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    state_e              state;
    logic [TRY_W-1:0]    try_cnt;
    logic [LOCK_W-1:0]   lock_cnt;
    logic [IDLE_W-1:0]   idle_cnt;

    logic [FIELD_W-1:0]  num_field;
    logic [VEC_W-1:0]    num_ins;
    logic                num_valid;
    logic [VEC_W-1:0]    price_ins;
    logic                price_valid;
    // Current price is irrelevant when overwriting it.
    logic [FIELD_W-1:0]  unused_price_field;
    logic [FIELD_W:0]    restock_sum;

    // One extra bit so an overflowing restock is detected rather than wrapped.
    assign restock_sum = {1'b0, num_field} + {1'b0, in_value};

    vm_field u_stock (
        .vec     (all_number),
        .idx     (index_type),
        .new_val (restock_sum[FIELD_W-1:0]),
        .field   (num_field),
        .vec_out (num_ins),
        .valid   (num_valid)
    );

    vm_field u_price (
        .vec     (all_price),
        .idx     (index_type),
        .new_val (in_value),
        .field   (unused_price_field),
        .vec_out (price_ins),
        .valid   (price_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_LOCKED;
            try_cnt            <= '0;
            lock_cnt           <= '0;
            idle_cnt           <= '0;
            update_all_number  <= '0;
            update_all_price   <= '0;
            update_saved_money <= '0;
            withdrawn          <= '0;
            done               <= 1'b0;
            error              <= 1'b0;
            unlocked           <= 1'b0;
            locked_out         <= 1'b0;
        end else begin
            done               <= 1'b0;
            error              <= 1'b0;
            update_all_number  <= all_number;
            update_all_price   <= all_price;
            update_saved_money <= saved_money;

            if (mode != MODE_OWNER) begin
                // Leaving owner mode drops any request; the try count survives
                // so toggling mode cannot be used to reset the PIN attempts.
                state      <= ST_LOCKED;
                unlocked   <= 1'b0;
                locked_out <= 1'b0;
                idle_cnt   <= '0;
                lock_cnt   <= '0;
            end else begin
                case (state)
                    ST_LOCKED: begin
                        if (req) begin
                            done <= 1'b1;
                            if (in_value == PIN) begin
                                state    <= ST_UNLOCKED;
                                unlocked <= 1'b1;
                                try_cnt  <= '0;
                                idle_cnt <= '0;
                            end else begin
                                error <= 1'b1;
                                if (try_cnt >= TRY_W'(MAX_TRIES - 1)) begin
                                    state      <= ST_LOCKOUT;
                                    locked_out <= 1'b1;
                                    try_cnt    <= TRY_W'(MAX_TRIES);
                                    lock_cnt   <= LOCK_W'(LOCK_CYCLES - 1);
                                end else begin
                                    try_cnt <= try_cnt + 1'b1;
                                end
                            end
                        end
                    end

                    ST_LOCKOUT: begin
                        if (lock_cnt == '0) begin
                            state      <= ST_LOCKED;
                            locked_out <= 1'b0;
                            try_cnt    <= '0;
                        end else begin
                            lock_cnt <= lock_cnt - 1'b1;
                        end
                    end

                    ST_UNLOCKED: begin
                        if (req) begin
                            // A request on the expiry edge wins over the timeout.
                            idle_cnt <= '0;
                            done     <= 1'b1;
                            case (cmd_e'(cmd))
                                CMD_RESTOCK: begin
                                    if (!num_valid || restock_sum > (FIELD_W+1)'(MAX_QTY))
                                        error <= 1'b1;
                                    else
                                        update_all_number <= num_ins;
                                end
                                CMD_SET_PRICE: begin
                                    if (!price_valid || in_value == '0)
                                        error <= 1'b1;
                                    else
                                        update_all_price <= price_ins;
                                end
                                CMD_WITHDRAW: begin
                                    if (in_value > saved_money) begin
                                        error <= 1'b1;
                                    end else begin
                                        update_saved_money <= saved_money - in_value;
                                        withdrawn          <= in_value;
                                    end
                                end
                                CMD_LOGOUT: begin
                                    state    <= ST_LOCKED;
                                    unlocked <= 1'b0;
                                end
                            endcase
                        end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                            state    <= ST_LOCKED;
                            unlocked <= 1'b0;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end

                    default: begin
                        state      <= ST_LOCKED;
                        unlocked   <= 1'b0;
                        locked_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vending_owner.sv
// tb_vending_owner: scenario-driven bench for vending_owner. Expected output
// snapshots are queued as each stimulus is applied and compared one cycle
// later against the registered outputs.
module tb_vending_owner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'b01;
    logic        req = 1'b0;
    logic [1:0]  cmd = 2'b00;
    logic [2:0]  index_type = 3'd0;
    logic [3:0]  in_value = 4'd0;
    logic [19:0] all_number = 20'h00000;
    logic [19:0] all_price = 20'h12345;
    logic [3:0]  saved_money = 4'd10;
    logic [19:0] update_all_number;
    logic [19:0] update_all_price;
    logic [3:0]  update_saved_money;
    logic [3:0]  withdrawn;
    logic        done, error, unlocked, locked_out;

    always #5 clk = ~clk;

    vending_owner dut (
        .clk                (clk),
        .rst                (rst),
        .mode               (mode),
        .req                (req),
        .cmd                (cmd),
        .index_type         (index_type),
        .in_value           (in_value),
        .all_number         (all_number),
        .all_price          (all_price),
        .saved_money        (saved_money),
        .update_all_number  (update_all_number),
        .update_all_price   (update_all_price),
        .update_saved_money (update_saved_money),
        .withdrawn          (withdrawn),
        .done               (done),
        .error              (error),
        .unlocked           (unlocked),
        .locked_out         (locked_out)
    );

    typedef struct packed {
        logic        done;
        logic        error;
        logic        unlocked;
        logic        locked_out;
        logic [19:0] num;
        logic [19:0] price;
        logic [3:0]  money;
        logic [3:0]  wd;
    } snap_t;

    snap_t       sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [3:0]  wd_model = 4'd0;

    function automatic snap_t mk(logic d, logic e, logic u, logic l,
                                 logic [19:0] num, logic [19:0] price,
                                 logic [3:0] money, logic [3:0] wd);
        snap_t s;
        s.done = d; s.error = e; s.unlocked = u; s.locked_out = l;
        s.num = num; s.price = price; s.money = money; s.wd = wd;
        return s;
    endfunction

    // Expected snapshot when no field is written: outputs echo the inputs.
    function automatic snap_t pass(logic d, logic e, logic u, logic l);
        return mk(d, e, u, l, all_number, all_price, saved_money, wd_model);
    endfunction

    function automatic snap_t observe();
        return mk(done, error, unlocked, locked_out, update_all_number,
                  update_all_price, update_saved_money, withdrawn);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic r, logic [1:0] c, logic [2:0] idx, logic [3:0] v);
        req = r; cmd = c; index_type = idx; in_value = v;
    endtask

    task automatic test_reset();
        snap_t o, x;
        rst = 1'b1;
        tick();
        sb.push_back(mk(0, 0, 0, 0, 20'h0, 20'h0, 4'd0, 4'd0));
        tick();
        o = observe(); x = sb.pop_front(); checks++;
        if (o !== x) begin failures++; $display("FAIL reset got=%h exp=%h", o, x); end
        rst = 1'b0;
        sb.push_back(pass(0, 0, 0, 0));
        tick();
        o = observe(); x = sb.pop_front(); checks++;
        if (o !== x) begin failures++; $display("FAIL reset_idle got=%h exp=%h", o, x); end
    endtask

    task automatic test_unlock();
        snap_t o, x;
        drive(1, 2'b00, 3'd0, 4'd9);
        sb.push_back(pass(1, 0, 1, 0));
        tick();
        drive(0, 2'b00, 3'd0, 4'd0);
        o = observe(); x = sb.pop_front(); checks++;
        if (o !== x) begin failures++; $display("FAIL unlock got=%h exp=%h", o, x); end
        sb.push_back(pass(0, 0, 1, 0));
        tick();
        o = observe(); x = sb.pop_front(); checks++;
        if (o !== x) begin failures++; $display("FAIL unlock_hold got=%h exp=%h", o, x); end
    endtask

    task automatic test_restock();
        logic [19:0] num_in [4]  = '{20'h00040, 20'h000B0, 20'h000B0, 20'h000F0};
        logic [2:0]  idx    [4]  = '{3'd2, 3'd2, 3'd2, 3'd0};
        logic [3:0]  val    [4]  = '{4'd7, 4'd5, 4'd4, 4'd1};
        logic [19:0] num_ex [4]  = '{20'h000B0, 20'h000B0, 20'h000F0, 20'h000F0};
        logic        err_ex [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        snap_t o, x;
        for (int i = 0; i < 4; i++) begin
            all_number = num_in[i];
            drive(1, 2'b00, idx[i], val[i]);
            sb.push_back(mk(1, err_ex[i], 1, 0, num_ex[i], all_price, saved_money, wd_model));
            tick();
            o = observe(); x = sb.pop_front(); checks++;
            if (o !== x) begin failures++; $display("FAIL restock_%0d got=%h exp=%h", i, o, x); end
        end
        drive(0, 2'b00, 3'd0, 4'd0);
    endtask

    task automatic test_price();
        logic [19:0] pr_in [4] = '{20'h12345, 20'h62345, 20'h62345, 20'h62345};
        logic [2:0]  idx   [4] = '{3'd5, 3'd5, 3'd6, 3'd1};
        logic [3:0]  val   [4] = '{4'd6, 4'd0, 4'd3, 4'd15};
        logic [19:0] pr_ex [4] = '{20'h62345, 20'h62345, 20'h62345, 20'h6234F};
        logic        err_ex[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        snap_t o, x;
        for (int i = 0; i < 4; i++) begin
            all_price = pr_in[i];
            drive(1, 2'b01, idx[i], val[i]);
            sb.push_back(mk(1, err_ex[i], 1, 0, all_number, pr_ex[i], saved_money, wd_model));
            tick();
            o = observe(); x = sb.pop_front(); checks++;
            if (o !== x) begin failures++; $display("FAIL price_%0d got=%h exp=%h", i, o, x); end
        end
        drive(0, 2'b00, 3'd0, 4'd0);
    endtask

    task automatic test_withdraw();
        logic [3:0] val   [3] = '{4'd4, 4'd12, 4'd10};
        logic [3:0] mon_ex[3] = '{4'd6, 4'd10, 4'd0};
        logic [3:0] wd_ex [3] = '{4'd4, 4'd4, 4'd10};
        logic       err_ex[3] = '{1'b0, 1'b1, 1'b0};
        snap_t o, x;
        saved_money = 4'd10;
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b10, 3'd1, val[i]);
            wd_model = wd_ex[i];
            sb.push_back(mk(1, err_ex[i], 1, 0, all_number, all_price, mon_ex[i], wd_model));
            tick();
            o = observe(); x = sb.pop_front(); checks++;
            if (o !== x) begin failures++; $display("FAIL withdraw_%0d got=%h exp=%h", i, o, x); end
        end
        drive(0, 2'b00, 3'd0, 4'd0);
    endtask

    task automatic test_back_to_back();
        snap_t o, x;
        all_number = 20'h00000;
        drive(1, 2'b00, 3'd1, 4'd1);
        sb.push_back(mk(1, 0, 1, 0, 20'h00001, all_price, saved_money, wd_model));
        tick();
        o = observe(); x = sb.pop_front(); checks++;
        if (o !== x) begin failures++; $display("FAIL b2b_0 got=%h exp=%h", o, x); end
        drive(1, 2'b00, 3'd3, 4'd2);
        sb.push_back(mk(1, 0, 1, 0, 20'h00200, all_price, saved_money, wd_model));
        tick();
        o = observe(); x = sb.pop_front(); checks++;
        if (o !== x) begin failures++; $display("FAIL b2b_1 got=%h exp=%h", o, x); end
        drive(1, 2'b10, 3'd0, 4'd1);
        wd_model = 4'd1;
        sb.push_back(mk(1, 0, 1, 0, all_number, all_price, 4'd9, 4'd1));
        tick();
        o = observe(); x = sb.pop_front(); checks++;
        if (o !== x) begin failures++; $display("FAIL b2b_2 got=%h exp=%h", o, x); end
        drive(0, 2'b00, 3'd0, 4'd0);
    endtask

    task automatic test_timeout();
        snap_t o, x;
        drive(1, 2'b11, 3'd0, 4'd0);
        sb.push_back(pass(1, 0, 0, 0));
        tick();
        o = observe(); x = sb.pop_front(); checks++;
        if (o !== x) begin failures++; $display("FAIL logout got=%h exp=%h", o, x); end
        for (int pass_n = 0; pass_n < 2; pass_n++) begin
            drive(1, 2'b00, 3'd0, 4'd9);
            sb.push_back(pass(1, 0, 1, 0));
            tick();
            o = observe(); x = sb.pop_front(); checks++;
            if (o !== x) begin failures++; $display("FAIL to_unlock_%0d got=%h exp=%h", pass_n, o, x); end
            drive(0, 2'b00, 3'd0, 4'd0);
            for (int seg = 0; seg <= pass_n; seg++) begin
                for (int k = 1; k <= 31; k++) begin
                    sb.push_back(pass(0, 0, 1, 0));
                    tick();
                    o = observe(); x = sb.pop_front(); checks++;
                    if (o !== x) begin failures++; $display("FAIL idle_%0d_%0d got=%h exp=%h", pass_n, k, o, x); end
                end
                if (seg < pass_n) begin
                    // request lands on the expiry edge and must win
                    drive(1, 2'b00, 3'd1, 4'd0);
                    sb.push_back(pass(1, 0, 1, 0));
                    tick();
                    o = observe(); x = sb.pop_front(); checks++;
                    if (o !== x) begin failures++; $display("FAIL req_at_expiry got=%h exp=%h", o, x); end
                    drive(0, 2'b00, 3'd0, 4'd0);
                end
            end
            sb.push_back(pass(0, 0, 0, 0));
            tick();
            o = observe(); x = sb.pop_front(); checks++;
            if (o !== x) begin failures++; $display("FAIL timeout_%0d got=%h exp=%h", pass_n, o, x); end
        end
    endtask

    task automatic test_lockout();
        snap_t o, x;
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b00, 3'd0, 4'd3);
            sb.push_back(pass(1, 1, 0, (i == 2)));
            tick();
            o = observe(); x = sb.pop_front(); checks++;
            if (o !== x) begin failures++; $display("FAIL bad_pin_%0d got=%h exp=%h", i, o, x); end
        end
        // correct PIN held during lockout must be ignored
        drive(1, 2'b00, 3'd0, 4'd9);
        for (int k = 1; k <= 16; k++) begin
            sb.push_back(pass(0, 0, 0, (k < 16)));
            tick();
            o = observe(); x = sb.pop_front(); checks++;
            if (o !== x) begin failures++; $display("FAIL lockout_%0d got=%h exp=%h", k, o, x); end
        end
        sb.push_back(pass(1, 0, 1, 0));
        tick();
        o = observe(); x = sb.pop_front(); checks++;
        if (o !== x) begin failures++; $display("FAIL unlock_after_lockout got=%h exp=%h", o, x); end
        drive(0, 2'b00, 3'd0, 4'd0);
    endtask

    task automatic test_mode_exit();
        snap_t o, x;
        mode = 2'b00;
        drive(1, 2'b00, 3'd1, 4'd1);
        sb.push_back(pass(0, 0, 0, 0));
        tick();
        o = observe(); x = sb.pop_front(); checks++;
        if (o !== x) begin failures++; $display("FAIL mode_exit got=%h exp=%h", o, x); end
        mode = 2'b01;
        drive(0, 2'b00, 3'd0, 4'd0);
        sb.push_back(pass(0, 0, 0, 0));
        tick();
        o = observe(); x = sb.pop_front(); checks++;
        if (o !== x) begin failures++; $display("FAIL mode_back got=%h exp=%h", o, x); end
        drive(1, 2'b00, 3'd0, 4'd9);
        sb.push_back(pass(1, 0, 1, 0));
        tick();
        o = observe(); x = sb.pop_front(); checks++;
        if (o !== x) begin failures++; $display("FAIL relogin got=%h exp=%h", o, x); end
        drive(0, 2'b00, 3'd0, 4'd0);
        rst = 1'b1;
        wd_model = 4'd0;
        sb.push_back(mk(0, 0, 0, 0, 20'h0, 20'h0, 4'd0, 4'd0));
        tick();
        o = observe(); x = sb.pop_front(); checks++;
        if (o !== x) begin failures++; $display("FAIL mid_reset got=%h exp=%h", o, x); end
        rst = 1'b0;
        sb.push_back(pass(0, 0, 0, 0));
        tick();
        o = observe(); x = sb.pop_front(); checks++;
        if (o !== x) begin failures++; $display("FAIL after_reset got=%h exp=%h", o, x); end
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_restock();
        test_price();
        test_withdraw();
        test_back_to_back();
        test_timeout();
        test_lockout();
        test_mode_exit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
